// File: rtl/simon_pkg.sv
// Shared constants and helpers for the Simon game datapath.
package simon_pkg;

  // Galois taps for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form).
  localparam logic [15:0] LfsrPoly    = 16'hB400;
  localparam logic [15:0] DefaultSeed = 16'hACE1;

  // True when exactly one bit is set.
  function automatic logic is_onehot(input logic [15:0] v);
    return (v != 16'd0) && ((v & (v - 16'd1)) == 16'd0);
  endfunction

  // Pad index to one-hot LED/pad vector.
  function automatic logic [15:0] idx_to_onehot(input logic [3:0] idx);
    return 16'd1 << idx;
  endfunction

  // One Galois LFSR step.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? LfsrPoly : 16'd0);
  endfunction

endpackage

// File: rtl/simon_datapath_gen_if.sv
// Controller/board-facing bundle of the Simon datapath.
interface simon_datapath_gen_if #(
  parameter int unsigned PADS  = 4,
  parameter int unsigned DEPTH = 64
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic            level;
  logic            auto_mode;
  logic [PADS-1:0] pattern;
  logic            clear;
  logic            append;
  logic            rst_i;
  logic            count_i;
  logic            show_input;

  logic            right_guess;
  logic            i_eq_ns;
  logic            legal;
  logic            full;
  logic            empty;
  logic [AW:0]     seq_len;
  logic [AW:0]     high_score;
  logic [PADS-1:0] pattern_leds;

  modport master (
    output level, auto_mode, pattern, clear, append, rst_i, count_i, show_input,
    input  right_guess, i_eq_ns, legal, full, empty, seq_len, high_score, pattern_leds
  );

  modport slave (
    input  level, auto_mode, pattern, clear, append, rst_i, count_i, show_input,
    output right_guess, i_eq_ns, legal, full, empty, seq_len, high_score, pattern_leds
  );

endinterface

// File: rtl/simon_seq_mem.sv
// DEPTH x PADS sequence store: synchronous write, combinational read, sync clear.
module simon_seq_mem #(
  parameter int unsigned PADS  = 4,
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            clear_n,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [PADS-1:0] wdata,
  input  logic [AW-1:0]   raddr,
  output logic [PADS-1:0] rdata
);

  logic [PADS-1:0] mem [DEPTH];

  // Clear wipes every entry and takes priority over a write.
  always_ff @(posedge clk) begin
    if (!clear_n) begin
      mem <= '{default: '0};
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/simon_datapath_gen.sv
// Simon datapath: sequence length/replay counters, LFSR pad generator,
// high-score tracking and LED/guess output muxing.
module simon_datapath_gen
  import simon_pkg::*;
#(
  parameter int unsigned PADS  = 4,
  parameter int unsigned DEPTH = 64,
  parameter logic [15:0] SEED  = DefaultSeed
) (
  input  logic               clk,
  input  logic               reset_n,
  simon_datapath_gen_if.slave bus
);

  localparam int unsigned AW     = $clog2(DEPTH);
  localparam int unsigned PW     = $clog2(PADS);
  localparam logic [AW:0] NsOne  = 1;
  localparam logic [AW:0] NsFull = DEPTH[AW:0];

  logic [AW:0]     ns_q, ns_d;
  logic [AW:0]     i_q, i_d;
  logic [AW:0]     hs_q, hs_d;
  logic [15:0]     lfsr_q;
  logic [PADS-1:0] cur;
  logic [PADS-1:0] gen_pad;
  logic [PADS-1:0] wdata;
  logic            we;
  logic            full_int;
  logic            i_lt_ns;

  assign gen_pad  = PADS'(idx_to_onehot(4'(lfsr_q[PW-1:0])));
  assign full_int = (ns_q == NsFull);
  assign i_lt_ns  = (i_q < ns_q);
  // A clear in the same cycle cancels the append.
  assign we       = bus.append && !bus.clear && !full_int;
  assign wdata    = bus.auto_mode ? gen_pad : bus.pattern;

  // Next-state for length, replay index and high score.
  always_comb begin
    ns_d = ns_q;
    i_d  = i_q;
    hs_d = hs_q;
    if (bus.clear) begin
      ns_d = '0;
      i_d  = '0;
      if (ns_q > hs_q) hs_d = ns_q;
    end else begin
      if (we) ns_d = ns_q + NsOne;
      // Saturation compares against the pre-append length.
      if (bus.rst_i) begin
        i_d = '0;
      end else if (bus.count_i && i_lt_ns) begin
        i_d = i_q + NsOne;
      end
    end
  end

  // State registers; the LFSR free-runs every non-reset cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ns_q   <= '0;
      i_q    <= '0;
      hs_q   <= '0;
      lfsr_q <= SEED;
    end else begin
      ns_q   <= ns_d;
      i_q    <= i_d;
      hs_q   <= hs_d;
      lfsr_q <= lfsr_step(lfsr_q);
    end
  end

  simon_seq_mem #(
    .PADS  (PADS),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .clear_n (reset_n),
    .we      (we),
    .waddr   (ns_q[AW-1:0]),
    .wdata   (wdata),
    .raddr   (i_q[AW-1:0]),
    .rdata   (cur)
  );

  assign bus.right_guess  = i_lt_ns && (cur == bus.pattern);
  assign bus.legal        = bus.level ? (bus.pattern != '0) : is_onehot(16'(bus.pattern));
  assign bus.pattern_leds = bus.show_input ? bus.pattern : (i_lt_ns ? cur : '0);
  assign bus.i_eq_ns      = (i_q == ns_q);
  assign bus.full         = full_int;
  assign bus.empty        = (ns_q == '0);
  assign bus.seq_len      = ns_q;
  assign bus.high_score   = hs_q;

endmodule
